// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types, encodings and decode helpers for the multicycle controller
//
// Purpose: state enum, instruction field encodings, datapath mux encodings,
//          condition codes and the cmd decode helpers used by the FSM.
// Ports:   none (package).
// Config:  MC_CMP_EN - when defined, cmd 1010 (CMP) is a supported command
//          decoding to SUB.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE,
      S_MEMWB, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
   } state_t;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   // Unsupported commands still run through the ALU as ADD but must not
   // write registers or flags.
   function automatic logic cmd_supported(input logic [3:0] cmd);
      case (cmd)
         CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR: return 1'b1;
`ifdef MC_CMP_EN
         CMD_CMP: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
      case (cmd)
         CMD_SUB: return ALU_SUB;
         CMD_AND: return ALU_AND;
         CMD_ORR: return ALU_ORR;
`ifdef MC_CMP_EN
         CMD_CMP: return ALU_SUB;
`endif
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mc_cond_check.sv
// rtl/mc_cond_check.sv - architectural NZCV flags and condition evaluation
//
// Purpose: holds the NZ and CV flag registers and evaluates the instruction
//          condition field against them.
// Ports:   clk, reset       - clock, async active-high reset (clears flags)
//          cond[3:0]        - instruction condition field
//          aluflags[3:0]    - live ALU flags {N,Z,C,V}
//          nz_we, cv_we     - flag register load enables
//          condex_next      - condition result from the registered flags
module mc_cond_check
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [3:0] aluflags,
   input  logic       nz_we,
   input  logic       cv_we,
   output logic       condex_next
);

   logic [1:0] nz;
   logic [1:0] cv;
   logic       n, z, c, v;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nz <= 2'b00;
         cv <= 2'b00;
      end else begin
         if (nz_we) nz <= aluflags[3:2];
         if (cv_we) cv <= aluflags[1:0];
      end
   end

   assign n = nz[1];
   assign z = nz[0];
   assign c = cv[1];
   assign v = cv[0];

   always_comb begin
      condex_next = 1'b0;
      case (cond)
         COND_EQ: condex_next = z;
         COND_NE: condex_next = ~z;
         COND_CS: condex_next = c;
         COND_CC: condex_next = ~c;
         COND_MI: condex_next = n;
         COND_PL: condex_next = ~n;
         COND_VS: condex_next = v;
         COND_VC: condex_next = ~v;
         COND_HI: condex_next = c & ~z;
         COND_LS: condex_next = ~c | z;
         COND_GE: condex_next = (n == v);
         COND_LT: condex_next = (n != v);
         COND_GT: condex_next = ~z & (n == v);
         COND_LE: condex_next = z | (n != v);
         COND_AL: condex_next = 1'b1;
         default: condex_next = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing the shared multicycle datapath
//
// Purpose: steps fetch/decode/execute/memory/writeback, drives datapath mux
//          selects and enables, and gates state-changing strobes with condex.
// Ports:   clk, reset               - clock, async active-high reset
//          cond, op, funct, rd      - instruction register fields
//          aluflags[3:0]            - live ALU flags {N,Z,C,V}
//          pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
//          alucontrol, immsrc, regwrite, regsrc - datapath controls
// Config:  MC_CMP_EN - when defined, CMP (cmd 1010) is SUB with forced S and
//          returns to FETCH straight from EXECUTE without writeback.
module multicycle_controller
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic [3:0] rd,
   input  logic [3:0] aluflags,
   output logic       pcwrite,
   output logic       adrsrc,
   output logic       memwrite,
   output logic       irwrite,
   output logic [1:0] resultsrc,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] alucontrol,
   output logic [1:0] immsrc,
   output logic       regwrite,
   output logic [1:0] regsrc
);

   state_t     state, next_state;
   logic       condex;
   logic       condex_next;
   logic [3:0] cmd;
   logic       cmd_ok;
   logic       is_cmp;
   logic       set_flags;
   logic       arith;
   logic       nz_we, cv_we;

   assign cmd    = funct[4:1];
   assign cmd_ok = cmd_supported(cmd);
`ifdef MC_CMP_EN
   assign is_cmp = (cmd == CMD_CMP);
`else
   assign is_cmp = 1'b0;
`endif
   assign set_flags = (funct[0] | is_cmp) & cmd_ok;
   assign arith     = (cmd == CMD_ADD) | (cmd == CMD_SUB) | is_cmp;

   // Flags load on the edge leaving EXECUTE; condex here is the value captured
   // at DECODE, so the update never feeds back into this instruction.
   assign nz_we = ((state == S_EXECUTER) | (state == S_EXECUTEI)) & condex & set_flags;
   assign cv_we = nz_we & arith;

   mc_cond_check u_cond (
      .clk         (clk),
      .reset       (reset),
      .cond        (cond),
      .aluflags    (aluflags),
      .nz_we       (nz_we),
      .cv_we       (cv_we),
      .condex_next (condex_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_FETCH;
         condex <= 1'b0;
      end else begin
         state <= next_state;
         if (state == S_DECODE) condex <= condex_next;
      end
   end

   assign immsrc = op;
   assign regsrc = {op == OP_MEM, op == OP_BR};

   always_comb begin
      next_state = state;
      pcwrite    = 1'b0;
      adrsrc     = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      resultsrc  = RES_ALUOUT;
      alusrca    = 1'b0;
      alusrcb    = SRCB_REG;
      alucontrol = ALU_ADD;
      regwrite   = 1'b0;
      case (state)
         S_FETCH: begin
            next_state = S_DECODE;
            irwrite    = 1'b1;
            pcwrite    = 1'b1;
            alusrca    = 1'b1;
            alusrcb    = SRCB_FOUR;
            resultsrc  = RES_ALU;
         end
         S_DECODE: begin
            alusrca   = 1'b1;
            alusrcb   = SRCB_FOUR;
            resultsrc = RES_ALU;
            case (op)
               OP_MEM:  next_state = S_MEMADR;
               OP_DP:   next_state = funct[5] ? S_EXECUTEI : S_EXECUTER;
               OP_BR:   next_state = S_BRANCH;
               default: next_state = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alusrcb    = SRCB_IMM;
            next_state = funct[0] ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adrsrc     = 1'b1;
            next_state = S_MEMWB;
         end
         S_MEMWRITE: begin
            adrsrc     = 1'b1;
            memwrite   = condex;
            next_state = S_FETCH;
         end
         S_MEMWB: begin
            resultsrc  = RES_DATA;
            regwrite   = condex;
            pcwrite    = condex & (rd == 4'd15);
            next_state = S_FETCH;
         end
         S_EXECUTER, S_EXECUTEI: begin
            alusrcb    = (state == S_EXECUTEI) ? SRCB_IMM : SRCB_REG;
            alucontrol = alu_decode(cmd);
            next_state = is_cmp ? S_FETCH : S_ALUWB;
         end
         S_ALUWB: begin
            resultsrc  = RES_ALUOUT;
            regwrite   = condex & cmd_ok;
            pcwrite    = condex & cmd_ok & (rd == 4'd15);
            next_state = S_FETCH;
         end
         S_BRANCH: begin
            alusrcb    = SRCB_IMM;
            resultsrc  = RES_ALU;
            pcwrite    = condex;
            next_state = S_FETCH;
         end
         default: next_state = S_FETCH;
      endcase
      // Strobes are killed combinationally so an abort takes effect in the
      // same cycle reset rises.
      if (reset) begin
         pcwrite  = 1'b0;
         irwrite  = 1'b0;
         memwrite = 1'b0;
         regwrite = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] aluflags;
   logic       pcwrite, adrsrc, memwrite, irwrite, alusrca, regwrite;
   logic [1:0] resultsrc, alusrcb, alucontrol, immsrc, regsrc;

   int checks = 0;
   int errors = 0;

`ifdef MC_CMP_EN
   localparam bit CMP_EN = 1'b1;
`else
   localparam bit CMP_EN = 1'b0;
`endif

   logic [3:0]  mflags;          // architectural {N,Z,C,V} as the model sees them
   logic [15:0] exp_v [5];
   logic [15:0] obs_v [5];
   int          n_cyc;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .rd(rd),
      .aluflags(aluflags), .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite),
      .irwrite(irwrite), .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
      .alucontrol(alucontrol), .immsrc(immsrc), .regwrite(regwrite), .regsrc(regsrc)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] pk(input logic pcw, input logic adr, input logic memw,
                                      input logic irw, input logic [1:0] res, input logic srca,
                                      input logic [1:0] srcb, input logic [1:0] alu,
                                      input logic [1:0] imm, input logic regw,
                                      input logic [1:0] rs);
      return {pcw, adr, memw, irw, res, srca, srcb, alu, imm, regw, rs};
   endfunction

   function automatic logic [15:0] observed();
      return {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
              alucontrol, immsrc, regwrite, regsrc};
   endfunction

   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      {n, z, cf, v} = f;
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cf;
         4'd3:  return !cf;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cf && !z;
         4'd9:  return !cf || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Entered #1 after the edge that starts FETCH; leaves at the same point of
   // the next instruction's FETCH. Builds the expected per-cycle controls from
   // the instruction class and records what the DUT showed.
   task automatic exec_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input logic [3:0] af);
      logic       ce, is_cmp, known, arith, wr;
      logic [3:0] cmd;
      logic [1:0] aluop, rs;
      cond = c; op = o; funct = f; rd = r; aluflags = af;
      ce     = cond_holds(c, mflags);
      rs     = {o == 2'b01, o == 2'b10};
      cmd    = f[4:1];
      is_cmp = CMP_EN && (cmd == 4'b1010);
      known  = 1'b1;
      aluop  = 2'b00;
      if (cmd == 4'b0100) aluop = 2'b00;
      else if (cmd == 4'b0010 || is_cmp) aluop = 2'b01;
      else if (cmd == 4'b0000) aluop = 2'b10;
      else if (cmd == 4'b1100) aluop = 2'b11;
      else known = 1'b0;
      arith = (cmd == 4'b0100) || (cmd == 4'b0010) || is_cmp;
      exp_v[0] = pk(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10, 2'b00, o, 1'b0, rs);
      exp_v[1] = pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, o, 1'b0, rs);
      n_cyc = 2;
      case (o)
         2'b00: begin
            exp_v[2] = pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, {1'b0, f[5]}, aluop, o, 1'b0, rs);
            n_cyc = 3;
            if (!is_cmp) begin
               wr = ce && known;
               exp_v[3] = pk(wr && (r == 4'd15), 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00,
                             o, wr, rs);
               n_cyc = 4;
            end
            if (ce && known && (f[0] || is_cmp)) begin
               mflags[3:2] = af[3:2];
               if (arith) mflags[1:0] = af[1:0];
            end
         end
         2'b01: begin
            exp_v[2] = pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, o, 1'b0, rs);
            if (f[0]) begin
               exp_v[3] = pk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, o, 1'b0, rs);
               exp_v[4] = pk(ce && (r == 4'd15), 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00,
                             o, ce, rs);
               n_cyc = 5;
            end else begin
               exp_v[3] = pk(1'b0, 1'b1, ce, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, o, 1'b0, rs);
               n_cyc = 4;
            end
         end
         2'b10: begin
            exp_v[2] = pk(ce, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 2'b00, o, 1'b0, rs);
            n_cyc = 3;
         end
         default: n_cyc = 2;
      endcase
      for (int k = 0; k < n_cyc; k++) begin
         @(negedge clk);
         obs_v[k] = observed();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] want;
      reset = 1'b1;
      cond = 4'($urandom); op = 2'($urandom); funct = 6'($urandom); rd = 4'($urandom);
      aluflags = 4'($urandom);
      want = pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, op,
                1'b0, {op == 2'b01, op == 2'b10});
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (observed() !== want) begin
            errors++;
            $display("FAIL reset_outputs cyc%0d got %h want %h", k, observed(), want);
         end
      end
      @(posedge clk);
      #1 reset = 1'b0;
      mflags = 4'b0000;
      // Cleared Z: BEQ must not take, BNE must.
      exec_instr(4'b0000, 2'b10, 6'h00, 4'd0, 4'hF);
      for (int k = 0; k < n_cyc; k++) begin
         checks++;
         if (obs_v[k] !== exp_v[k]) begin
            errors++;
            $display("FAIL reset_beq cyc%0d got %h want %h", k, obs_v[k], exp_v[k]);
         end
      end
      exec_instr(4'b0001, 2'b10, 6'h00, 4'd0, 4'hF);
      for (int k = 0; k < n_cyc; k++) begin
         checks++;
         if (obs_v[k] !== exp_v[k]) begin
            errors++;
            $display("FAIL reset_bne cyc%0d got %h want %h", k, obs_v[k], exp_v[k]);
         end
      end
   endtask

   task automatic test_directed();
      logic [3:0] tc [14] = '{4'hE, 4'h0, 4'hE, 4'h0, 4'hE, 4'hE, 4'h1, 4'h0, 4'h1, 4'hE,
                               4'hE, 4'h0, 4'hE, 4'hA};
      logic [1:0] to [14] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10,
                               2'b11, 2'b00, 2'b10, 2'b00, 2'b10};
      logic [5:0] tf [14] = '{6'b001001, 6'h00, 6'b001001, 6'h00, 6'b000001, 6'b001001,
                               6'b000000, 6'b001001, 6'h00, 6'h3F, 6'b111000, 6'h00,
                               6'b000101, 6'h00};
      logic [3:0] tr [14] = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd15, 4'd1, 4'd2, 4'd3, 4'd0, 4'd15,
                               4'd3, 4'd0, 4'd4, 4'd0};
      logic [3:0] ta [14] = '{4'b0100, 4'h0, 4'b0000, 4'h0, 4'h0, 4'b0100, 4'h0, 4'b0000,
                               4'h0, 4'hF, 4'hF, 4'h0, 4'b1011, 4'h0};
      for (int i = 0; i < 14; i++) begin
         exec_instr(tc[i], to[i], tf[i], tr[i], ta[i]);
         for (int k = 0; k < n_cyc; k++) begin
            checks++;
            if (obs_v[k] !== exp_v[k]) begin
               errors++;
               $display("FAIL directed_%0d cyc%0d got %h want %h", i, k, obs_v[k], exp_v[k]);
            end
         end
      end
   endtask

   task automatic test_cmp();
      logic [5:0] tf [6] = '{6'b001001, 6'b010101, 6'h00, 6'b010100, 6'b000011, 6'h00};
      logic [3:0] tc [6] = '{4'hE, 4'hE, 4'h0, 4'hE, 4'hE, 4'h0};
      logic [1:0] to [6] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10};
      logic [3:0] ta [6] = '{4'b0000, 4'b0100, 4'h0, 4'b0000, 4'b0100, 4'h0};
      for (int i = 0; i < 6; i++) begin
         exec_instr(tc[i], to[i], tf[i], 4'd5, ta[i]);
         for (int k = 0; k < n_cyc; k++) begin
            checks++;
            if (obs_v[k] !== exp_v[k]) begin
               errors++;
               $display("FAIL cmp_%0d cyc%0d got %h want %h", i, k, obs_v[k], exp_v[k]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] want;
      // Set Z so the post-reset branch shows the flags were cleared.
      exec_instr(4'hE, 2'b00, 6'b001001, 4'd1, 4'b0100);
      cond = 4'hE; op = 2'b01; funct = 6'b011000; rd = 4'd2;
      for (int k = 0; k < 4; k++) @(negedge clk);
      checks++;
      if (memwrite !== 1'b1) begin
         errors++;
         $display("FAIL mid_memwrite_before got %b want 1", memwrite);
      end
      #2 reset = 1'b1;
      #1;
      want = pk(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 2'b01, 1'b0, 2'b10);
      checks++;
      if (observed() !== want) begin
         errors++;
         $display("FAIL mid_reset_same_cycle got %h want %h", observed(), want);
      end
      @(posedge clk);
      #1;
      checks++;
      if (observed() !== want) begin
         errors++;
         $display("FAIL mid_reset_held got %h want %h", observed(), want);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      mflags = 4'b0000;
      exec_instr(4'h0, 2'b10, 6'h00, 4'd0, 4'h0);
      for (int k = 0; k < n_cyc; k++) begin
         checks++;
         if (obs_v[k] !== exp_v[k]) begin
            errors++;
            $display("FAIL mid_after_beq cyc%0d got %h want %h", k, obs_v[k], exp_v[k]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         exec_instr(4'($urandom_range(0, 15)), 2'($urandom), 6'($urandom),
                    4'($urandom), 4'($urandom));
         for (int k = 0; k < n_cyc; k++) begin
            checks++;
            if (obs_v[k] !== exp_v[k]) begin
               errors++;
               $display("FAIL random_%0d cyc%0d got %h want %h", i, k, obs_v[k], exp_v[k]);
            end
         end
      end
   endtask

   initial begin
      mflags = 4'b0000;
      test_reset();
      test_directed();
      test_cmp();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle sequencer for the ARM-subset processor. Replaces the single-cycle control path with a Moore FSM that steps one shared memory/ALU datapath through fetch, decode, execute, memory and writeback. Keeps architectural NZCV flags and gates all state-changing strobes with the condition result. Sits between the instruction register fields and the multicycle datapath muxes and enables.

## Interface
No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces FETCH and clears flags
- cond  in  4  instr[31:28]
- op  in  2  instr[27:26]; 00 data-processing, 01 memory, 10 branch, 11 undefined
- funct  in  6  instr[25:20]; [5]=I, [4:1]=cmd, [0]=S (memory: [0]=L)
- rd  in  4  instr[15:12]
- aluflags  in  4  live ALU flags {N,Z,C,V}
- pcwrite  out  1  PC load enable
- adrsrc  out  1  memory address: 0 PC, 1 ALUOut
- memwrite  out  1  data memory write
- irwrite  out  1  instruction register load
- resultsrc  out  2  00 ALUOut, 01 data reg, 10 ALU result
- alusrca  out  1  0 reg A, 1 PC
- alusrcb  out  2  00 reg B, 01 extended immediate, 10 constant 4
- alucontrol  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- immsrc  out  2  equals op
- regwrite  out  1  register file write
- regsrc  out  2  [0]=(op==10), [1]=(op==01)

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWRITE, MEMWB, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE: op 01→MEMADR, op 00 & I=0→EXECUTER, op 00 & I=1→EXECUTEI, op 10→BRANCH, op 11→FETCH.
  - MEMADR: L=1→MEMREAD, L=0→MEMWRITE.
  - MEMREAD→MEMWB. MEMWRITE, MEMWB, ALUWB, BRANCH→FETCH. EXECUTER/EXECUTEI→ALUWB.
- Outputs by state; unlisted outputs are 0:
  - FETCH: irwrite=1, pcwrite=1, alusrca=1, alusrcb=10, ADD, resultsrc=10.
  - DECODE: alusrca=1, alusrcb=10, resultsrc=10.
  - MEMADR: alusrcb=01, ADD.
  - MEMREAD: adrsrc=1.
  - MEMWRITE: adrsrc=1, memwrite=condex.
  - MEMWB: resultsrc=01, regwrite=condex.
  - EXECUTER: alusrcb=00, decoded ALU op. EXECUTEI: alusrcb=01, decoded ALU op.
  - ALUWB: resultsrc=00, regwrite=condex.
  - BRANCH: alusrcb=01, ADD, resultsrc=10, pcwrite=condex.
- Writes to r15: in MEMWB/ALUWB with rd==15, pcwrite=condex in addition to regwrite.
- cmd decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - Any other cmd decodes as ADD with regwrite and flag writes suppressed.
- Flag registers: NZ is written when S=1; CV is written when S=1 and cmd is ADD/SUB.
  - Both are loaded from aluflags on the edge leaving EXECUTER/EXECUTEI, only if condex.
- Condition codes: EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); AL 1; 1111→0.
- condex is evaluated against the registered flags and captured on the edge leaving DECODE.
  - It holds until the next DECODE, so a flag update in EXECUTE never affects the same instruction's writeback.
- cond/op/funct/rd are stable from DECODE to the end of the instruction; the datapath holds IR.

## Timing
- Latency in cycles including FETCH: branch 3, STR 4, data-processing 4, LDR 5, undefined 2.
- All outputs are combinational from state, the registered condex, and instruction fields.
  - There are no combinational paths from aluflags to outputs.
- Reset asserted: state=FETCH, flags=0000, condex=0.
  - pcwrite, irwrite, memwrite and regwrite are forced 0 while reset is high.
  - Other outputs show FETCH values.
- Reset mid-instruction aborts it immediately; no strobe fires after reset asserts.
- Deassertion: the first rising edge with reset low completes FETCH.

## Configuration
- MC_CMP_EN defined: cmd 1010 (CMP) decodes as SUB with S forced to 1.
  - EXECUTER/EXECUTEI go directly to FETCH, skipping ALUWB. Latency is 3 and regwrite is never asserted.
- MC_CMP_EN undefined: cmd 1010 is unsupported per the rule above.

## Structure
- Package mc_pkg holds:
  - the state enum typedef;
  - op encodings (OP_DP, OP_MEM, OP_BR);
  - cmd constants;
  - alucontrol encodings;
  - resultsrc/alusrcb encodings;
  - condition-code constants.
- Sub-module mc_cond_check: NZ/CV flag registers plus the combinational cond evaluation, outputting condex_next.
  - The FSM registers condex from condex_next.

## Test plan
- Reset high mid-MEMWRITE → memwrite drops the same cycle; after release the first edge ends FETCH and the next state is DECODE.
- ADDS r1 (op=00, funct=001001, rd=1) with aluflags=0100 → regwrite pulses in ALUWB on cycle 4; flags read 0100 afterward.
- Following BEQ (cond=0000, op=10) → pcwrite=1 in BRANCH. Repeat with the flags' Z=0 → pcwrite=0, and the sequence still returns to FETCH after 3 cycles.
- LDR (op=01, funct[0]=1, rd=15) → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; in MEMWB resultsrc=01 and regwrite=pcwrite=1.
- STRNE (cond=0001) with Z=1 → memwrite stays 0 throughout; op=11 → DECODE→FETCH, with no strobes beyond FETCH.
- CMP (cmd=1010, S=1): with MC_CMP_EN → 3 cycles, alucontrol=01, flags update, no regwrite. Without MC_CMP_EN → 4 cycles, no regwrite, flags unchanged.
